// File: rtl/wave_pkg.sv
// Shared definitions for the ROM waveform player: FSM state encoding and playback mode.
package wave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } wave_state_t;

  localparam logic MODE_LOOP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/rom_lat_pipe.sv
// Valid delay line matching the ROM read latency; tail marks the cycle rom_data is usable.
module rom_lat_pipe #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic tail
);

  logic [LAT-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < LAT; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign tail = sr[LAT-1];

endmodule

// File: rtl/rom_wave_player.sv
// ROM waveform sequencer: paced reads over a wrapping table segment, latency-aligned DAC output.
module rom_wave_player
  import wave_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int DIV_W   = 8,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [ADDR_W-1:0] cfg_start_addr,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic              cfg_oneshot,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] da_data,
  output logic              da_valid,
  output logic              busy,
  output logic              done,
  output wave_state_t       fsm_state
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int DR_W  = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

  wave_state_t       state;
  logic [DIV_W-1:0]  div_l;
  logic [DIV_W-1:0]  div_cnt;
  logic [ADDR_W-1:0] start_l;
  logic [ADDR_W:0]   len_l;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   last_idx;
  logic              oneshot_l;
  logic [DR_W-1:0]   drain_cnt;
  logic              pipe_tail;

  assign last_idx  = len_l - CNT_W'(1);
  assign busy      = (state != ST_IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      div_l     <= '0;
      div_cnt   <= '0;
      start_l   <= '0;
      len_l     <= '0;
      idx       <= '0;
      oneshot_l <= MODE_LOOP;
      drain_cnt <= '0;
      rom_addr  <= '0;
      rom_en    <= 1'b0;
      done      <= 1'b0;
    end else begin
      rom_en <= 1'b0;
      done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          // start wins over a simultaneous stop; config is frozen here for the whole run
          if (start) begin
            div_l     <= cfg_div;
            start_l   <= cfg_start_addr;
            len_l     <= (cfg_len == '0) ? FULL_LEN : cfg_len;
            oneshot_l <= cfg_oneshot;
            div_cnt   <= '0;
            idx       <= '0;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end else begin
            div_cnt <= (div_cnt == div_l) ? '0 : div_cnt + DIV_W'(1);
            if (div_cnt == '0) begin
              rom_en   <= 1'b1;
              rom_addr <= start_l + idx[ADDR_W-1:0];
              if (idx == last_idx) begin
                idx <= '0;
                if (oneshot_l == MODE_ONESHOT) begin
                  state     <= ST_DRAIN;
                  drain_cnt <= '0;
                end
              end else begin
                idx <= idx + CNT_W'(1);
              end
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DR_W'(ROM_LAT - 1)) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            drain_cnt <= drain_cnt + DR_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  rom_lat_pipe #(.LAT(ROM_LAT)) u_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  (rom_en),
    .tail (pipe_tail)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      da_data  <= '0;
      da_valid <= 1'b0;
    end else begin
      da_valid <= pipe_tail;
      if (pipe_tail) begin
        da_data <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_rom_wave_player.sv
// Directed bench for rom_wave_player: two instances (ROM_LAT 1 and 2) driven by the same stimulus.
module tb_rom_wave_player;
  import wave_pkg::*;

  localparam int ADDR_W = 10;
  localparam int LOGN   = 2048;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        cfg_div;
  logic [ADDR_W-1:0] cfg_start_addr;
  logic [ADDR_W:0]   cfg_len;
  logic              cfg_oneshot;
  logic              start;
  logic              stop;

  logic              rom_en_s   [2];
  logic [ADDR_W-1:0] rom_addr_s [2];
  logic [31:0]       da_data_s  [2];
  logic              da_valid_s [2];
  logic              busy_s     [2];
  logic              done_s     [2];
  wave_state_t       st_s       [2];

  logic [31:0] rom0_q, rom1_a, rom1_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] addr_log [2][LOGN];
  logic [31:0] data_log [2][LOGN];
  int          en_cyc   [2][LOGN];
  int          val_cyc  [2][LOGN];
  int          n_en [2];
  int          n_v  [2];
  int          n_done [2];
  int          done_cyc [2];
  logic        done_busy [2];
  int          mark_en [2];
  int          mark_v [2];
  int          mark_done [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rom_wave_player #(.DATA_W(32), .ADDR_W(ADDR_W), .DIV_W(8), .ROM_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .cfg_div(cfg_div), .cfg_start_addr(cfg_start_addr),
    .cfg_len(cfg_len), .cfg_oneshot(cfg_oneshot), .start(start), .stop(stop),
    .rom_addr(rom_addr_s[0]), .rom_en(rom_en_s[0]), .rom_data(rom0_q),
    .da_data(da_data_s[0]), .da_valid(da_valid_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .fsm_state(st_s[0])
  );

  rom_wave_player #(.DATA_W(32), .ADDR_W(ADDR_W), .DIV_W(8), .ROM_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .cfg_div(cfg_div), .cfg_start_addr(cfg_start_addr),
    .cfg_len(cfg_len), .cfg_oneshot(cfg_oneshot), .start(start), .stop(stop),
    .rom_addr(rom_addr_s[1]), .rom_en(rom_en_s[1]), .rom_data(rom1_b),
    .da_data(da_data_s[1]), .da_valid(da_valid_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .fsm_state(st_s[1])
  );

  function automatic logic [31:0] rom_val(input logic [ADDR_W-1:0] a);
    return 32'hA500_0000 | {22'd0, a};
  endfunction

  // ROM models: data = tag | address, 1 and 2 cycles of read latency
  always @(posedge clk) begin
    if (rom_en_s[0]) rom0_q <= rom_val(rom_addr_s[0]);
    if (rom_en_s[1]) rom1_a <= rom_val(rom_addr_s[1]);
    rom1_b <= rom1_a;
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rom_en_s[k] === 1'b1) begin
        if (n_en[k] < LOGN) begin
          addr_log[k][n_en[k]] = {22'd0, rom_addr_s[k]};
          en_cyc[k][n_en[k]]   = cyc;
        end
        n_en[k] = n_en[k] + 1;
      end
      if (da_valid_s[k] === 1'b1) begin
        if (n_v[k] < LOGN) begin
          data_log[k][n_v[k]] = da_data_s[k];
          val_cyc[k][n_v[k]]  = cyc;
        end
        n_v[k] = n_v[k] + 1;
      end
      if (done_s[k] === 1'b1) begin
        n_done[k]    = n_done[k] + 1;
        done_cyc[k]  = cyc;
        done_busy[k] = busy_s[k];
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mark_all();
    for (int k = 0; k < 2; k++) begin
      mark_en[k]   = n_en[k];
      mark_v[k]    = n_v[k];
      mark_done[k] = n_done[k];
    end
  endtask

  task automatic set_cfg(input int dv, input int sa, input int ln, input logic os);
    cfg_div        = 8'(dv);
    cfg_start_addr = ADDR_W'(sa);
    cfg_len        = (ADDR_W+1)'(ln);
    cfg_oneshot    = os;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while ((busy_s[0] || busy_s[1]) && n < max) begin
      tick(1);
      n++;
    end
    chk({tag, "_timeout"}, {31'd0, busy_s[0] | busy_s[1]}, 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_rom_en"},   {31'd0, rom_en_s[k]},   32'd0);
      chk({tag, "_rom_addr"}, {22'd0, rom_addr_s[k]}, 32'd0);
      chk({tag, "_da_data"},  da_data_s[k],           32'd0);
      chk({tag, "_da_valid"}, {31'd0, da_valid_s[k]}, 32'd0);
      chk({tag, "_done"},     {31'd0, done_s[k]},     32'd0);
      chk({tag, "_busy"},     {31'd0, busy_s[k]},     32'd0);
      chk({tag, "_state"},    {30'd0, st_s[k]},       {30'd0, ST_IDLE});
    end
  endtask

  // Compare one playback against the expected read schedule; stop_c < 0 means natural end.
  task automatic check_play(input string tag, input int exp_n, input int st, input int len,
                            input int dv, input int start_c, input int stop_c);
    for (int k = 0; k < 2; k++) begin
      int lat  = k + 1;
      int b    = mark_en[k];
      int bv   = mark_v[k];
      int got  = n_en[k] - b;
      int gotv = n_v[k] - bv;
      int m    = (got < exp_n) ? got : exp_n;
      int mv   = (gotv < exp_n) ? gotv : exp_n;
      int bad;
      int ix;
      logic [31:0] ea;
      if (b + m > LOGN) m = LOGN - b;
      if (bv + mv > LOGN) mv = LOGN - bv;
      chk({tag, "_n_rom_en"}, got, exp_n);
      chk({tag, "_n_da_valid"}, gotv, exp_n);
      chk({tag, "_n_done"}, n_done[k] - mark_done[k], 1);
      if (m > 0) begin
        chk({tag, "_first_read_cyc"}, en_cyc[k][b], start_c + 2);
        bad = -1;
        for (int i = 0; i < m; i++) begin
          ea = 32'((st + (i % len)) % 1024);
          if (addr_log[k][b+i] !== ea) begin bad = i; break; end
        end
        ix = (bad >= 0) ? bad : m - 1;
        chk({tag, "_addr"}, addr_log[k][b+ix], 32'((st + (ix % len)) % 1024));
        bad = -1;
        for (int i = 1; i < m; i++) begin
          if (en_cyc[k][b+i] - en_cyc[k][b+i-1] != dv + 1) begin bad = i; break; end
        end
        if (m > 1) begin
          ix = (bad >= 0) ? bad : m - 1;
          chk({tag, "_read_spacing"}, en_cyc[k][b+ix] - en_cyc[k][b+ix-1], dv + 1);
        end
        chk({tag, "_done_cyc"}, done_cyc[k],
            (stop_c < 0) ? en_cyc[k][b+m-1] + lat : stop_c + 1 + lat);
        chk({tag, "_busy_at_done"}, {31'd0, done_busy[k]}, 32'd0);
      end
      if (mv > 0) begin
        bad = -1;
        for (int i = 0; i < mv; i++) begin
          ea = rom_val(ADDR_W'((st + (i % len)) % 1024));
          if (data_log[k][bv+i] !== ea) begin bad = i; break; end
        end
        ix = (bad >= 0) ? bad : mv - 1;
        chk({tag, "_da_data"}, data_log[k][bv+ix], rom_val(ADDR_W'((st + (ix % len)) % 1024)));
        if (m > 0) begin
          bad = -1;
          for (int i = 0; i < ((m < mv) ? m : mv); i++) begin
            if (val_cyc[k][bv+i] - en_cyc[k][b+i] != lat + 1) begin bad = i; break; end
          end
          ix = (bad >= 0) ? bad : (((m < mv) ? m : mv) - 1);
          chk({tag, "_latency"}, val_cyc[k][bv+ix] - en_cyc[k][b+ix], lat + 1);
        end
      end
    end
  endtask

  initial begin
    int c0;
    int s0;
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    set_cfg(0, 0, 1, 1'b0);
    tick(3);
    check_outputs_zero("reset");
    rst = 1'b0;
    tick(2);

    // loop, every cycle, stopped after 10 reads
    mark_all();
    set_cfg(0, 0, 4, MODE_LOOP);
    c0 = cyc; start = 1'b1; tick(1); start = 1'b0;
    tick(10);
    s0 = cyc; stop = 1'b1; tick(1); stop = 1'b0;
    wait_idle("t1", 50);
    tick(5);
    check_play("t1_loop", 10, 0, 4, 0, c0, s0);

    // one-shot with divider 3
    mark_all();
    set_cfg(3, 10, 3, MODE_ONESHOT);
    c0 = cyc; start = 1'b1; tick(1); start = 1'b0;
    wait_idle("t2", 100);
    tick(5);
    check_play("t2_div3", 3, 10, 3, 3, c0, -1);

    // wrap past top of table
    mark_all();
    set_cfg(0, 1022, 4, MODE_ONESHOT);
    c0 = cyc; start = 1'b1; tick(1); start = 1'b0;
    wait_idle("t3a", 50);
    tick(5);
    check_play("t3_wrap", 4, 1022, 4, 0, c0, -1);

    // len 0 plays the full table
    mark_all();
    set_cfg(0, 5, 0, MODE_ONESHOT);
    c0 = cyc; start = 1'b1; tick(1); start = 1'b0;
    wait_idle("t3b", 1200);
    tick(5);
    check_play("t3_full", 1024, 5, 1024, 0, c0, -1);

    // stop coincides with the 6th read slot
    mark_all();
    set_cfg(1, 100, 3, MODE_LOOP);
    c0 = cyc; start = 1'b1; tick(1); start = 1'b0;
    tick(10);
    s0 = cyc; stop = 1'b1; tick(1); stop = 1'b0;
    wait_idle("t4", 50);
    tick(5);
    check_play("t4_stop", 5, 100, 3, 1, c0, s0);

    // start and config changes while running are ignored
    mark_all();
    set_cfg(2, 200, 4, MODE_ONESHOT);
    c0 = cyc; start = 1'b1; tick(1); start = 1'b0;
    tick(2);
    set_cfg(0, 7, 9, MODE_LOOP);
    start = 1'b1; tick(1); start = 1'b0;
    wait_idle("t5a", 100);
    tick(5);
    check_play("t5_busy_start", 4, 200, 4, 2, c0, -1);

    // start and stop together in IDLE: start taken
    mark_all();
    set_cfg(0, 300, 2, MODE_ONESHOT);
    c0 = cyc; start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0;
    wait_idle("t5b", 50);
    tick(5);
    check_play("t5_start_stop", 2, 300, 2, 0, c0, -1);

    // reset mid-run with reads in flight
    set_cfg(0, 50, 8, MODE_LOOP);
    start = 1'b1; tick(1); start = 1'b0;
    tick(3);
    rst = 1'b1; tick(1);
    check_outputs_zero("t6_rst");
    rst = 1'b0;
    mark_all();
    tick(12);
    for (int k = 0; k < 2; k++) begin
      chk("t6_no_rom_en",   n_en[k] - mark_en[k], 0);
      chk("t6_no_da_valid", n_v[k] - mark_v[k], 0);
      chk("t6_no_done",     n_done[k] - mark_done[k], 0);
      chk("t6_idle",        {31'd0, busy_s[k]}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
